// File: rtl/jk_latch_controller_if.sv
// jk_latch_controller_if: requester handshake and JK latch-bank bus of the controller
// Signals: req0/req1, cmd0/cmd1, mask0/mask1 (requester commands), ack0/ack1 (completion pulses),
//          q_in (latch feedback), j_out/k_out/en (latch drive), busy, err (status).
// Modports: master drives requests and latch feedback, slave is the controller.
interface jk_latch_controller_if #(parameter int WIDTH = 4);
    logic             req0, req1;
    logic [1:0]       cmd0, cmd1;
    logic [WIDTH-1:0] mask0, mask1;
    logic [WIDTH-1:0] q_in;
    logic [WIDTH-1:0] j_out, k_out;
    logic             en;
    logic             ack0, ack1;
    logic             busy;
    logic             err;
    modport master (
        output req0, req1, cmd0, cmd1, mask0, mask1, q_in,
        input  j_out, k_out, en, ack0, ack1, busy, err
    );
    modport slave (
        input  req0, req1, cmd0, cmd1, mask0, mask1, q_in,
        output j_out, k_out, en, ack0, ack1, busy, err
    );
endinterface

// File: rtl/jk_latch_controller.sv
// jk_latch_controller: two-requester round-robin driver of a WIDTH-bit JK latch bank
// Ports: clk (rising edge), rst_n (async active-low), bus (jk_latch_controller_if.slave):
//        requests/commands/masks in, ack0/ack1 out, q_in feedback in, j_out/k_out/en drive out,
//        busy and err status out.
// Optional feature: define JK_CTRL_CHECK_EN to add the CHECK state and result compare (err);
//        without it err is tied low and SETTLE goes straight to ACK.
module jk_latch_controller #(
    parameter int WIDTH = 4
) (
    input logic                 clk,
    input logic                 rst_n,
    jk_latch_controller_if.slave bus
);
`ifdef JK_CTRL_CHECK_EN
    typedef enum logic [2:0] {IDLE, DRIVE, SETTLE, CHECK, ACK} state_t;
`else
    typedef enum logic [2:0] {IDLE, DRIVE, SETTLE, ACK} state_t;
`endif
    state_t           state_q, state_d;
    logic             last_q, last_d;
    logic             win1, grant;
    logic [1:0]       sel_cmd;
    logic [WIDTH-1:0] sel_mask;
    logic             en_q, en_d;
    logic [WIDTH-1:0] j_q, j_d, k_q, k_d;
    logic             ack0_q, ack0_d, ack1_q, ack1_d;
    // On a tie the requester not granted last time wins; last_q also names the current grant.
    assign win1     = bus.req1 & (~bus.req0 | ~last_q);
    assign grant    = (state_q == IDLE) & (bus.req0 | bus.req1);
    assign sel_cmd  = win1 ? bus.cmd1 : bus.cmd0;
    assign sel_mask = win1 ? bus.mask1 : bus.mask0;
    always_comb begin
        state_d = state_q;
        last_d  = last_q;
        case (state_q)
            IDLE: begin
                state_d = grant ? DRIVE : IDLE;
                last_d  = grant ? win1 : last_q;
            end
            DRIVE:  state_d = SETTLE;
`ifdef JK_CTRL_CHECK_EN
            SETTLE: state_d = CHECK;
            CHECK:  state_d = ACK;
`else
            SETTLE: state_d = ACK;
`endif
            ACK:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end
    // Outputs are registered from the next state so en/j/k appear in the DRIVE cycle itself.
    assign en_d   = state_d == DRIVE;
    assign j_d    = en_d ? sel_mask & {WIDTH{sel_cmd[1]}} : '0;
    assign k_d    = en_d ? sel_mask & {WIDTH{sel_cmd[0]}} : '0;
    assign ack0_d = (state_d == ACK) & ~last_q;
    assign ack1_d = (state_d == ACK) & last_q;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            last_q  <= 1'b1;
            en_q    <= 1'b0;
            j_q     <= '0;
            k_q     <= '0;
            ack0_q  <= 1'b0;
            ack1_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            last_q  <= last_d;
            en_q    <= en_d;
            j_q     <= j_d;
            k_q     <= k_d;
            ack0_q  <= ack0_d;
            ack1_q  <= ack1_d;
        end
    end
`ifdef JK_CTRL_CHECK_EN
    logic [1:0]       cmd_q, cmd_d;
    logic [WIDTH-1:0] mask_q, mask_d, q_pre_q, q_pre_d, f, exp_q;
    logic             err_q, err_d;
    assign cmd_d   = grant ? sel_cmd : cmd_q;
    assign mask_d  = grant ? sel_mask : mask_q;
    assign q_pre_d = grant ? bus.q_in : q_pre_q;
    assign f       = cmd_q == 2'b00 ? q_pre_q : cmd_q == 2'b01 ? '0 : cmd_q == 2'b10 ? '1 : ~q_pre_q;
    assign exp_q   = (q_pre_q & ~mask_q) | (mask_q & f);
    // err clears at each grant and is loaded once, on the CHECK exit edge.
    assign err_d   = grant ? 1'b0 : (state_q == CHECK) ? |(bus.q_in ^ exp_q) : err_q;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cmd_q   <= '0;
            mask_q  <= '0;
            q_pre_q <= '0;
            err_q   <= 1'b0;
        end else begin
            cmd_q   <= cmd_d;
            mask_q  <= mask_d;
            q_pre_q <= q_pre_d;
            err_q   <= err_d;
        end
    end
    assign bus.err = err_q;
`else
    assign bus.err = 1'b0;
`endif
    assign bus.en    = en_q;
    assign bus.j_out = j_q;
    assign bus.k_out = k_q;
    assign bus.ack0  = ack0_q;
    assign bus.ack1  = ack1_q;
    assign bus.busy  = state_q != IDLE;
endmodule
